// File: rtl/prod_accumulator.sv
// -----------------------------------------------------------------------------
// prod_accumulator
//
// Purpose:
//   This block sits after the 16x16 unsigned multiplier. It takes in a stream
//   of 32-bit products, grouped into frames by first/last flags. It adds up
//   each frame (one dot product) in a wide accumulator. Each finished sum is
//   held in a single-entry valid/ready output buffer. While that buffer is
//   stalled, the block applies backpressure to the product source.
//
// Parameters:
//   ACC_W  accumulator / out_sum width in bits (must be >= 32)
//   CNT_W  width of the per-frame beat counter (saturating)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   product beat valid
//   in_ready   block can accept a beat this cycle
//   in_prod    32-bit unsigned product
//   in_first   beat starts a new frame
//   in_last    beat ends the current frame
//   out_valid  out_sum/out_count/out_ovf hold a finished frame
//   out_ready  consumer accepts the result
//   out_sum    accumulated frame sum
//   out_count  number of beats in the frame, saturating
//   out_ovf    sum carried out of ACC_W bits at some point in the frame
//
// Build option:
//   ACC_SAT_EN  when defined, the accumulator clamps to all-ones on carry out
//               and stays there for the rest of the frame. Otherwise it wraps.
//               out_ovf is set in both cases.
// -----------------------------------------------------------------------------
module prod_accumulator #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_prod,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    state_t           state_reg;
    logic [ACC_W-1:0] acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             ovf_reg;

    logic             out_valid_reg;
    logic [ACC_W-1:0] out_sum_reg;
    logic [CNT_W-1:0] out_count_reg;
    logic             out_ovf_reg;

    logic             accept;
    logic             frame_start;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_next;

    // The only path from an input to an output is out_ready -> in_ready.
    // A stalled result blocks new beats, so the accumulator freezes too.
    assign in_ready    = !(out_valid_reg && !out_ready);
    assign accept      = in_valid && in_ready;
    // A beat that arrives with no frame open starts a frame, even if
    // in_first is low.
    assign frame_start = (state_reg == IDLE) || in_first;

    assign prod_ext = ACC_W'(in_prod);
    assign sum_wide = {1'b0, acc_reg} + {1'b0, prod_ext};

    always_comb begin
        acc_next = prod_ext;
        cnt_next = CNT_W'(1);
        ovf_next = 1'b0;
        if (!frame_start) begin
            ovf_next = ovf_reg || sum_wide[ACC_W];
            cnt_next = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + CNT_W'(1);
`ifdef ACC_SAT_EN
            // Once the frame has overflowed, the accumulator stays pinned at
            // the maximum value.
            acc_next = ovf_next ? ACC_MAX : sum_wide[ACC_W-1:0];
`else
            acc_next = sum_wide[ACC_W-1:0];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            out_sum_reg   <= '0;
            out_count_reg <= '0;
            out_ovf_reg   <= 1'b0;
        end else begin
            if (accept) begin
                acc_reg   <= acc_next;
                cnt_reg   <= cnt_next;
                ovf_reg   <= ovf_next;
                state_reg <= in_last ? IDLE : ACCUM;
            end
            // A new result may overwrite the buffer in the same cycle that
            // the old result drains. This lets single-beat frames run at
            // one result per cycle.
            if (accept && in_last) begin
                out_valid_reg <= 1'b1;
                out_sum_reg   <= acc_next;
                out_count_reg <= cnt_next;
                out_ovf_reg   <= ovf_next;
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_sum   = out_sum_reg;
    assign out_count = out_count_reg;
    assign out_ovf   = out_ovf_reg;

endmodule

// File: doc/prod_accumulator.md
Name: prod_accumulator

Overview:
- Downstream stage of the 16x16 unsigned multiplier.
- Consumes a stream of 32-bit products framed by first/last flags and accumulates each frame (one dot product) into a wide register.
- Presents each finished sum through a single-entry valid/ready output buffer, with backpressure to the product source.
- Forms the accumulate half of a systolic processing element.

Parameters:
- ACC_W, 40, accumulator and output sum width in bits; must be >= 32.
- CNT_W, 8, width of the per-frame beat counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  product beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_prod  input  32  unsigned product from the multiplier.
- in_first  input  1  beat starts a new frame.
- in_last  input  1  beat ends the current frame.
- out_valid  output  1  out_sum/out_count/out_ovf hold a finished frame.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  ACC_W  accumulated frame sum.
- out_count  output  CNT_W  number of beats in the frame, saturating.
- out_ovf  output  1  sum exceeded 2^ACC_W-1 at some point in the frame (sticky per frame).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: out_valid=0, out_sum=0, out_count=0, out_ovf=0, accumulator=0, beat counter=0, state=IDLE. Reset mid-frame discards the partial sum and any held result.
- Handshake:
  - Input beat accepted when in_valid & in_ready.
  - in_ready = !(out_valid & !out_ready). It is combinational from out_ready.
  - Output transfer occurs when out_valid & out_ready.
  - out_sum, out_count and out_ovf are stable while out_valid=1 and out_ready=0.
- States:
  - IDLE: no frame open. An accepted beat goes to ACCUM, or to IDLE again if in_last=1, loading acc = zero-extended in_prod, cnt=1 and ovf=0. A beat in IDLE without in_first is treated as a frame start.
  - ACCUM: an accepted beat without in_first adds acc = acc + in_prod and sets cnt = min(cnt+1, 2^CNT_W-1). An accepted beat with in_first abandons the open frame silently and restarts as from IDLE. An accepted beat with in_last moves to IDLE.
- Result publication:
  - Publication happens on the cycle a beat with in_last is accepted.
  - The final sum (including that beat), count and ovf are registered into the output.
  - out_valid=1 from the next cycle. Latency from last beat to out_valid is 1 cycle.
- in_first & in_last on the same beat: single-element frame. out_sum = in_prod, out_count=1.
- Simultaneous events:
  - If an output transfer and a last-beat acceptance occur in the same cycle, the new result overwrites the buffer and out_valid stays 1. Back-to-back single-beat frames therefore sustain one result per cycle.
  - If the output transfers with no new last beat, out_valid goes to 0 next cycle.
- Stall: while the output is held (out_valid=1, out_ready=0), in_ready=0 and the accumulator is frozen, including for non-last beats.
- Arithmetic: in_prod is zero-extended to ACC_W. The add is computed at ACC_W+1 bits. A carry out sets ovf for the frame; ovf clears on frame start.
- Count: out_count saturates at 2^CNT_W-1 and does not wrap.
- No combinational path from in_* to out_*.

Optional Feature:
- Macro: ACC_SAT_EN.
- When defined: on carry out the accumulator clamps to 2^ACC_W-1 and stays there for the rest of the frame. out_ovf is still set.
- When undefined: the sum wraps modulo 2^ACC_W and out_ovf is set.
- Frame-start and count behaviour are identical in both builds.

Test Plan:
- Reset then 3-beat frame 0x00000005, 0x00000007, 0x00000009 with first/last, out_ready=1 -> out_valid pulses 1 cycle after last, out_sum=21, out_count=3, out_ovf=0.
- Single beat first&last in_prod=0xFFFFFFFF -> out_sum=0x00FFFFFFFF, out_count=1. Repeat on 4 consecutive cycles -> 4 results on 4 consecutive cycles, in_ready constantly 1.
- Backpressure: hold out_ready=0 after a result, drive a next frame -> in_ready=0, outputs stable, accumulator unchanged. Raise out_ready -> transfer, in_ready=1 in the same cycle.
- ACC_W=33, frame of 3 x 0xFFFFFFFF -> without ACC_SAT_EN out_sum=0x0FFFFFFFD, out_ovf=1. With ACC_SAT_EN out_sum=0x1FFFFFFFF, out_ovf=1.
- Mid-frame in_first: beats 10 (first), 20, then 5 (first), 6 (last) -> single result out_sum=11, out_count=2. Separately, assert rst_n low after 2 beats -> no result, all outputs 0.
- CNT_W=2, 5-beat frame of value 1 -> out_sum=5, out_count=3 (saturated).
